vga_timing_ctrl: RTL and testbench



---
 rtl/vga_timing_ctrl.sv | 146 ++++++++++++++
 tb/tb_vga_timing_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_ctrl.sv
// Beam sequencer for the grayblast VGA path: x/y counters, sync/de decode,
// line and frame markers, and the look-ahead line fetch request.
module vga_timing_ctrl #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          SYNC_POL = 1'b0,
    parameter int unsigned LEAD     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pix_en,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       de,
    output logic       hsync,
    output logic       vsync,
    output logic       line_start,
    output logic       frame_start,
    output logic       line_req,
    output logic [9:0] req_line,
    output logic [7:0] frame_cnt
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_REQ  = 10'(H_TOTAL - LEAD);

    // Decode bounds carry an extra bit so a 1024-wide timing cannot alias to 0.
    localparam logic [10:0] H_ACT_L = 11'(H_ACTIVE);
    localparam logic [10:0] HS_BEG  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END  = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_ACT_L = 11'(V_ACTIVE);
    localparam logic [10:0] VS_BEG  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END  = 11'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic SYNC_ON  = SYNC_POL;
    localparam logic SYNC_OFF = ~SYNC_POL;

    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic       de_q, de_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       ls_q, ls_d;
    logic       fs_q, fs_d;
    logic       lr_q, lr_d;
    logic [9:0] rl_q, rl_d;
    logic [7:0] fc_q, fc_d;

    logic        x_wrap, y_wrap;
    logic [9:0]  x_nxt, y_nxt, n_line;
    logic [10:0] x_nxt_w, y_nxt_w, n_line_w;
    logic        in_hs, in_vs, in_de;

    always_comb begin
        x_wrap   = (x_q == H_LAST);
        y_wrap   = (y_q == V_LAST);
        x_nxt    = x_wrap ? 10'd0 : x_q + 10'd1;
        y_nxt    = x_wrap ? (y_wrap ? 10'd0 : y_q + 10'd1) : y_q;
        n_line   = (y_nxt == V_LAST) ? 10'd0 : y_nxt + 10'd1;
        x_nxt_w  = {1'b0, x_nxt};
        y_nxt_w  = {1'b0, y_nxt};
        n_line_w = {1'b0, n_line};
        in_hs    = (x_nxt_w >= HS_BEG) && (x_nxt_w < HS_END);
        in_vs    = (y_nxt_w >= VS_BEG) && (y_nxt_w < VS_END);
        in_de    = (x_nxt_w < H_ACT_L) && (y_nxt_w < V_ACT_L);
    end

    // Outputs are decoded from the post-advance count so they line up with x/y.
    always_comb begin
        x_d  = x_q;
        y_d  = y_q;
        de_d = de_q;
        hs_d = hs_q;
        vs_d = vs_q;
        ls_d = 1'b0;
        fs_d = 1'b0;
        lr_d = 1'b0;
        rl_d = rl_q;
        fc_d = fc_q;
        if (pix_en) begin
            x_d  = x_nxt;
            y_d  = y_nxt;
            de_d = in_de;
            hs_d = in_hs ? SYNC_ON : SYNC_OFF;
            vs_d = in_vs ? SYNC_ON : SYNC_OFF;
            ls_d = (x_nxt == 10'd0);
            fs_d = (x_nxt == 10'd0) && (y_nxt == 10'd0);
            if (fs_d) begin
                fc_d = fc_q + 8'd1;
            end
            // Blanking lines need no fetch, so only active next lines are requested.
            if ((x_nxt == H_REQ) && (n_line_w < V_ACT_L)) begin
                lr_d = 1'b1;
                rl_d = n_line;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q  <= H_LAST;
            y_q  <= V_LAST;
            de_q <= 1'b0;
            hs_q <= SYNC_OFF;
            vs_q <= SYNC_OFF;
            ls_q <= 1'b0;
            fs_q <= 1'b0;
            lr_q <= 1'b0;
            rl_q <= 10'd0;
            fc_q <= 8'd0;
        end else begin
            x_q  <= x_d;
            y_q  <= y_d;
            de_q <= de_d;
            hs_q <= hs_d;
            vs_q <= vs_d;
            ls_q <= ls_d;
            fs_q <= fs_d;
            lr_q <= lr_d;
            rl_q <= rl_d;
            fc_q <= fc_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign de          = de_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;
    assign line_req    = lr_q;
    assign req_line    = rl_q;
    assign frame_cnt   = fc_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Scoreboard bench: a default-timing and a tiny-timing instance share stimulus;
// expected outputs come from an arithmetic beam-position model.
module tb_vga_timing_ctrl;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       de;
        logic       hs;
        logic       vs;
        logic       ls;
        logic       fs;
        logic       lr;
        logic [9:0] rl;
        logic [7:0] fc;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic pix_en = 1'b0;

    logic [9:0] d_x, d_y, d_rl, s_x, s_y, s_rl;
    logic       d_de, d_hs, d_vs, d_ls, d_fs, d_lr;
    logic       s_de, s_hs, s_vs, s_ls, s_fs, s_lr;
    logic [7:0] d_fc, s_fc;

    int total = 0;
    int bad = 0;
    int nprint = 0;
    bit go = 1'b0;
    bit was_rst = 1'b0;

    int d_adv = 0, d_rl_m = 0;
    int s_adv = 0, s_rl_m = 0;
    obs_t q_d[$];
    obs_t q_s[$];

    always #5 clk = ~clk;

    vga_timing_ctrl dut_d (
        .clk(clk), .rst(rst), .pix_en(pix_en),
        .x(d_x), .y(d_y), .de(d_de), .hsync(d_hs), .vsync(d_vs),
        .line_start(d_ls), .frame_start(d_fs), .line_req(d_lr),
        .req_line(d_rl), .frame_cnt(d_fc)
    );

    vga_timing_ctrl #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1'b0), .LEAD(2)
    ) dut_s (
        .clk(clk), .rst(rst), .pix_en(pix_en),
        .x(s_x), .y(s_y), .de(s_de), .hsync(s_hs), .vsync(s_vs),
        .line_start(s_ls), .frame_start(s_fs), .line_req(s_lr),
        .req_line(s_rl), .frame_cnt(s_fc)
    );

    // Position after adv advances since reset: advance k lands on pixel k-1 of a raster scan.
    function automatic obs_t ref_model(input int adv, input bit stepped, input int rl_prev,
                                       input int ha, input int hf, input int hsw, input int hb,
                                       input int va, input int vf, input int vsw, input int vb,
                                       input int ld);
        obs_t o;
        int ht, vt, k, px, py, n;
        ht = ha + hf + hsw + hb;
        vt = va + vf + vsw + vb;
        if (adv == 0) begin
            px = ht - 1;
            py = vt - 1;
            o.fc = 8'd0;
        end else begin
            k = adv - 1;
            px = k % ht;
            py = (k / ht) % vt;
            o.fc = 8'(((k / (ht * vt)) + 1) % 256);
        end
        o.x  = 10'(px);
        o.y  = 10'(py);
        o.de = (px < ha) && (py < va);
        o.hs = !((px >= ha + hf) && (px < ha + hf + hsw));
        o.vs = !((py >= va + vf) && (py < va + vf + vsw));
        o.ls = stepped && (px == 0);
        o.fs = o.ls && (py == 0);
        n = (py == vt - 1) ? 0 : py + 1;
        o.lr = stepped && (px == ht - ld) && (n < va);
        o.rl = o.lr ? 10'(n) : 10'(rl_prev);
        return o;
    endfunction

    function automatic obs_t grab_d();
        obs_t a;
        a.x = d_x; a.y = d_y; a.de = d_de; a.hs = d_hs; a.vs = d_vs;
        a.ls = d_ls; a.fs = d_fs; a.lr = d_lr; a.rl = d_rl; a.fc = d_fc;
        return a;
    endfunction

    function automatic obs_t grab_s();
        obs_t a;
        a.x = s_x; a.y = s_y; a.de = s_de; a.hs = s_hs; a.vs = s_vs;
        a.ls = s_ls; a.fs = s_fs; a.lr = s_lr; a.rl = s_rl; a.fc = s_fc;
        return a;
    endfunction

    task automatic compare(input string name, input obs_t act, input obs_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (nprint < 40) begin
                nprint++;
                $display("FAIL %s t=%0t act x=%0d y=%0d de=%b hs=%b vs=%b ls=%b fs=%b lr=%b rl=%0d fc=%0d exp x=%0d y=%0d de=%b hs=%b vs=%b ls=%b fs=%b lr=%b rl=%0d fc=%0d",
                         name, $time, act.x, act.y, act.de, act.hs, act.vs, act.ls, act.fs, act.lr, act.rl, act.fc,
                         exp.x, exp.y, exp.de, exp.hs, exp.vs, exp.ls, exp.fs, exp.lr, exp.rl, exp.fc);
            end
        end
    endtask

    task automatic do_cycle(input bit r, input bit e);
        obs_t od, os;
        @(negedge clk);
        rst = r;
        pix_en = e;
        if (r) begin
            d_adv = 0; d_rl_m = 0;
            s_adv = 0; s_rl_m = 0;
        end else if (e) begin
            d_adv++;
            s_adv++;
        end
        od = ref_model(d_adv, !r && e, d_rl_m, 640, 16, 96, 48, 480, 10, 2, 33, 8);
        os = ref_model(s_adv, !r && e, s_rl_m, 4, 1, 1, 1, 3, 1, 1, 1, 2);
        d_rl_m = int'(od.rl);
        s_rl_m = int'(os.rl);
        q_d.push_back(od);
        q_s.push_back(os);
        go = 1'b1;
        if (r && !was_rst) begin
            #1;
            compare("dflt_async_rst", grab_d(), od);
            compare("small_async_rst", grab_s(), os);
        end
        was_rst = r;
    endtask

    always begin
        @(posedge clk);
        #1;
        if (go) begin
            total++;
            if (q_d.size() == 0 || q_s.size() == 0) begin
                bad++;
                $display("FAIL queue_underflow act d=%0d s=%0d exp nonzero", q_d.size(), q_s.size());
            end else begin
                total--;
                compare("dflt_obs", grab_d(), q_d.pop_front());
                compare("small_obs", grab_s(), q_s.pop_front());
            end
        end
    end

    initial begin
        int budget;
        #1 rst = 1'b1;
        was_rst = 1'b1;
        repeat (3) do_cycle(1'b1, 1'b0);
        repeat (100) do_cycle(1'b0, 1'b0);

        repeat (2000) do_cycle(1'b0, 1'b1);

        for (int i = 0; i < 3000; i++) do_cycle(1'b0, (i % 3) == 0);

        budget = 0;
        do begin
            do_cycle(1'b0, 1'b1);
            budget++;
        end while (((d_adv - 1) % 800) != 0 && budget < 1000);
        total++;
        if (budget >= 1000) begin
            bad++;
            $display("FAIL line_wrap_search act budget=%0d exp <1000", budget);
        end
        repeat (40) do_cycle(1'b0, 1'b0);

        for (int i = 0; i < 20000; i++) do_cycle(1'b0, $urandom_range(0, 3) != 0);

        repeat (3) do_cycle(1'b1, 1'($urandom_range(0, 1)));
        repeat (11000) do_cycle(1'b0, 1'b1);
        do_cycle(1'b0, 1'b0);

        @(posedge clk);
        #2;
        total++;
        if (q_d.size() != 0 || q_s.size() != 0) begin
            bad++;
            $display("FAIL queue_drain act d=%0d s=%0d exp 0", q_d.size(), q_s.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
